spi_xfer_ctrl: RTL and testbench
================================

# spi_xfer_ctrl

Sequencer that runs complete multi-byte SPI transactions on the byte-level SPI master core (CPOL=1/CPHA=1, chip select held low while enabled). It accepts a command of N write bytes followed by M read bytes and keeps the core's enable asserted across the whole transaction. It feeds write bytes from a one-entry prefetch buffer and returns read bytes on a pulsed stream. It sits between a host or register block and the SPI core, and is the only driver of the core's control inputs.

## Interface
- DUMMY_BYTE, 8'hFF: value shifted out during the read phase
- LEN_W, 8: width of wr_len/rd_len
- clk  in  1  system clock, all logic on rising edge
- arstn  in  1  asynchronous active-low reset
- start  in  1  command request, honoured only in IDLE
- wr_len  in  LEN_W  write bytes, sampled with start
- rd_len  in  LEN_W  read bytes, sampled with start
- abort  in  1  level; stop after the byte in flight
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command end
- status  out  2  00 ok, 01 tx underrun, 10 aborted; valid from done until next start
- tx_data  in  8  write byte stream
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  prefetch buffer accepts the byte this cycle
- rx_data  out  8  read byte
- rx_valid  out  1  one-cycle pulse per read byte
- spi_ena  out  1  to core ena_spi
- spi_byte_2_send  out  8  to core byte_2_send
- spi_byte_received  in  8  from core
- spi_end_trans  in  1  from core, high for one SCL period after each byte completes
- spi_new_byte  in  1  from core, unused except as a bench check

## Operation
- Reset values: busy=0, done=0, status=00, tx_ready=0, rx_data=0, rx_valid=0, spi_ena=0, spi_byte_2_send=0. FSM in IDLE, buffer empty, all counters 0.
- total = wr_len + rd_len, computed LEN_W+1 bits wide with no overflow. start with total=0 is ignored. start outside IDLE is ignored.
- Buffer: one byte plus a valid bit. tx_ready = busy & !buf_valid & (fetched < wr_len_q). A transfer occurs when tx_valid & tx_ready. fetched counts accepted bytes.
- FSM states:
  - IDLE -> PREP on accepted start. Latch lengths, clear counters, status=00.
  - PREP: first byte is buf when wr_len_q>0 (wait for buf_valid), else DUMMY_BYTE. When the byte is available, drive spi_byte_2_send, consume buf, set spi_ena=1 -> RUN. abort in PREP -> DONE with status=10; spi_ena is never raised.
  - RUN: a completion is a spi_end_trans rising edge, detected against a registered copy. On each completion, done_cnt increments. If the completed byte index is >= wr_len_q, rx_data is set to spi_byte_received and rx_valid pulses on the next cycle.
    - done_cnt==total after increment: spi_ena=0 -> DRAIN.
    - else abort=1: spi_ena=0, status=10 -> DRAIN.
    - else next index < wr_len_q and buf empty: spi_ena=0, status=01 -> DRAIN.
    - else: spi_byte_2_send is set to buf (consumed) or DUMMY_BYTE; spi_ena stays 1.
  - DRAIN: wait for spi_end_trans low -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Leftover unconsumed tx bytes stay in buf only until DONE, which clears buf. The host flushes its own source.
- Reset mid-transaction: all outputs return to reset values immediately. The core resets on the same arstn.

## Timing
- start at cycle T: busy=1 at T+1. spi_ena=1 no earlier than T+2 (PREP always takes at least one cycle).
- spi_byte_2_send is stable from spi_ena rise. It changes only within 2 cycles after a completion, well before the core reloads one SCL period later.
- spi_ena falls within 2 cycles of the final completion. The core therefore returns to idle and releases chip select at the end of that end_trans period.
- rx_valid is 2 cycles after the spi_end_trans rising edge.
- done is 1 cycle after spi_end_trans falls in DRAIN.
- Throughput: one byte per core byte period. There are no gaps beyond the core's inter-byte period.

## Test plan
- wr_len=1, rd_len=2, tx=0x9F, MISO model returns 0xEF,0x40 -> core shifts 0x9F,0xFF,0xFF under one continuous chip select. rx_valid pulses twice with 0xEF then 0x40. done with status=00, busy low after it.
- wr_len=4, rd_len=0, tx_valid held high with 0x02,0x00,0x10,0xAA -> MOSI sequence matches. No rx_valid. Exactly 4 completions, then done, status=00.
- wr_len=3, rd_len=1, tx_valid drops after 2 bytes -> 2 bytes shift, spi_ena falls after byte 2 completes. done with status=01, no rx_valid.
- abort raised during byte 2 of wr_len=2, rd_len=4 -> byte 2 completes, chip select released, done with status=10, no further bytes.
- start with wr_len=0, rd_len=0 -> no busy, no done. start during busy -> ignored, lengths unchanged.
- arstn low mid-RUN -> spi_ena=0, busy=0, rx_valid=0 that cycle. A new command after release runs normally.

Source files
------------

// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if: bundle between a host/register block, the transaction
// sequencer and the byte-level SPI master core.
//   command : start, wr_len, rd_len, abort -> busy, done, status
//   tx      : tx_data, tx_valid -> tx_ready (one-entry prefetch)
//   rx      : rx_data, rx_valid (one-cycle pulse per read byte)
//   core    : spi_ena, spi_byte_2_send -> spi_byte_received,
//             spi_end_trans, spi_new_byte
// master = host + core side, slave = the sequencer.
interface spi_xfer_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] wr_len;
    logic [LEN_W-1:0] rd_len;
    logic             abort;
    logic             busy;
    logic             done;
    logic [1:0]       status;

    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    logic [7:0]       rx_data;
    logic             rx_valid;

    logic             spi_ena;
    logic [7:0]       spi_byte_2_send;
    logic [7:0]       spi_byte_received;
    logic             spi_end_trans;
    logic             spi_new_byte;

    modport master (
        output start,
        output wr_len,
        output rd_len,
        output abort,
        output tx_data,
        output tx_valid,
        output spi_byte_received,
        output spi_end_trans,
        output spi_new_byte,
        input  busy,
        input  done,
        input  status,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  spi_ena,
        input  spi_byte_2_send
    );

    modport slave (
        input  start,
        input  wr_len,
        input  rd_len,
        input  abort,
        input  tx_data,
        input  tx_valid,
        input  spi_byte_received,
        input  spi_end_trans,
        input  spi_new_byte,
        output busy,
        output done,
        output status,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output spi_ena,
        output spi_byte_2_send
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: runs one SPI command of wr_len write bytes then rd_len
// read bytes on a byte-level SPI master core, holding its enable (and so
// chip select) across the whole command.
// Ports: clk, arstn (async active-low), bus (spi_xfer_ctrl_if.slave)
//   carrying the command, tx prefetch stream, rx pulse stream and the
//   core control/status signals.
module spi_xfer_ctrl #(
    parameter logic [7:0] DUMMY_BYTE = 8'hFF,
    parameter int          LEN_W     = 8
) (
    input  logic           clk,
    input  logic           arstn,
    spi_xfer_ctrl_if.slave bus
);

    localparam int CW = LEN_W + 1;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_UNDER = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [LEN_W-1:0] wr_len_q;
    logic [LEN_W-1:0] wr_len_d;
    logic [CW-1:0]    total_q;
    logic [CW-1:0]    total_d;
    logic [LEN_W-1:0] fetched_q;
    logic [LEN_W-1:0] fetched_d;
    logic [CW-1:0]    done_cnt_q;
    logic [CW-1:0]    done_cnt_d;

    logic [7:0]       buf_q;
    logic [7:0]       buf_d;
    logic             buf_vld_q;
    logic             buf_vld_d;

    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic [1:0]       status_q;
    logic [1:0]       status_d;

    logic [7:0]       rx_data_q;
    logic [7:0]       rx_data_d;
    logic             rx_pend_q;
    logic             rx_pend_d;
    logic             rx_valid_q;
    logic             rx_valid_d;

    logic             ena_q;
    logic             ena_d;
    logic [7:0]       tx_byte_q;
    logic [7:0]       tx_byte_d;
    logic             end_trans_q;

    logic [CW-1:0]    start_total;
    logic [CW-1:0]    wr_len_x;
    logic [CW-1:0]    cnt_inc;
    logic             tx_ready_w;
    logic             tx_fire;
    logic             end_rise;
    logic             rd_phase;
    logic             next_wr;

    assign start_total = CW'(bus.wr_len) + CW'(bus.rd_len);
    assign wr_len_x    = CW'(wr_len_q);
    assign cnt_inc     = done_cnt_q + CW'(1);

    assign tx_ready_w = busy_q & ~buf_vld_q & (fetched_q < wr_len_q);
    assign tx_fire    = bus.tx_valid & tx_ready_w;

    // A byte completes on the rising edge of end_trans; the level stays
    // high for a whole SCL period, so only the edge may count.
    assign end_rise = bus.spi_end_trans & ~end_trans_q;

    // Index of the byte just completed is done_cnt_q; the next one is
    // cnt_inc.
    assign rd_phase = done_cnt_q >= wr_len_x;
    assign next_wr  = cnt_inc < wr_len_x;

    always_comb begin
        state_d    = state_q;
        wr_len_d   = wr_len_q;
        total_d    = total_q;
        fetched_d  = fetched_q;
        done_cnt_d = done_cnt_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        status_d   = status_q;
        rx_data_d  = rx_data_q;
        rx_pend_d  = 1'b0;
        rx_valid_d = rx_pend_q;
        ena_d      = ena_q;
        tx_byte_d  = tx_byte_q;

        // Fill never collides with a consume: fill needs the buffer empty,
        // consume needs it full.
        if (tx_fire) begin
            buf_d     = bus.tx_data;
            buf_vld_d = 1'b1;
            fetched_d = fetched_q + LEN_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && (start_total != '0)) begin
                    state_d    = S_PREP;
                    wr_len_d   = bus.wr_len;
                    total_d    = start_total;
                    fetched_d  = '0;
                    done_cnt_d = '0;
                    buf_vld_d  = 1'b0;
                    busy_d     = 1'b1;
                    status_d   = ST_OK;
                end
            end

            S_PREP: begin
                if (bus.abort) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORT;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else if (wr_len_q != '0) begin
                    if (buf_vld_q) begin
                        tx_byte_d = buf_q;
                        buf_vld_d = 1'b0;
                        ena_d     = 1'b1;
                        state_d   = S_RUN;
                    end
                end else begin
                    tx_byte_d = DUMMY_BYTE;
                    ena_d     = 1'b1;
                    state_d   = S_RUN;
                end
            end

            S_RUN: begin
                if (end_rise) begin
                    done_cnt_d = cnt_inc;
                    if (rd_phase) begin
                        rx_data_d = bus.spi_byte_received;
                        rx_pend_d = 1'b1;
                    end
                    // Dropping ena during end_trans lets the core stop
                    // cleanly at the end of this byte.
                    if (cnt_inc == total_q) begin
                        ena_d   = 1'b0;
                        state_d = S_DRAIN;
                    end else if (bus.abort) begin
                        ena_d    = 1'b0;
                        status_d = ST_ABORT;
                        state_d  = S_DRAIN;
                    end else if (next_wr && !buf_vld_q) begin
                        ena_d    = 1'b0;
                        status_d = ST_UNDER;
                        state_d  = S_DRAIN;
                    end else if (next_wr) begin
                        tx_byte_d = buf_q;
                        buf_vld_d = 1'b0;
                    end else begin
                        tx_byte_d = DUMMY_BYTE;
                    end
                end
            end

            S_DRAIN: begin
                if (!bus.spi_end_trans) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            S_DONE: begin
                buf_vld_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= S_IDLE;
            wr_len_q    <= '0;
            total_q     <= '0;
            fetched_q   <= '0;
            done_cnt_q  <= '0;
            buf_q       <= '0;
            buf_vld_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= ST_OK;
            rx_data_q   <= '0;
            rx_pend_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            ena_q       <= 1'b0;
            tx_byte_q   <= '0;
            end_trans_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_len_q    <= wr_len_d;
            total_q     <= total_d;
            fetched_q   <= fetched_d;
            done_cnt_q  <= done_cnt_d;
            buf_q       <= buf_d;
            buf_vld_q   <= buf_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            status_q    <= status_d;
            rx_data_q   <= rx_data_d;
            rx_pend_q   <= rx_pend_d;
            rx_valid_q  <= rx_valid_d;
            ena_q       <= ena_d;
            tx_byte_q   <= tx_byte_d;
            end_trans_q <= bus.spi_end_trans;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.status          = status_q;
    assign bus.tx_ready        = tx_ready_w;
    assign bus.rx_data         = rx_data_q;
    assign bus.rx_valid        = rx_valid_q;
    assign bus.spi_ena         = ena_q;
    assign bus.spi_byte_2_send = tx_byte_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: scoreboard bench for spi_xfer_ctrl with a
// cycle-counting model of the byte-level SPI core.
module tb_spi_xfer_ctrl;
    localparam int         LEN_W = 8;
    localparam int         P     = 4;
    localparam logic [7:0] DUMMY = 8'hFF;

    logic clk = 1'b0;
    logic arstn;
    always #5 clk = ~clk;

    spi_xfer_ctrl_if #(.LEN_W(LEN_W)) bus ();

    spi_xfer_ctrl #(
        .DUMMY_BYTE(DUMMY),
        .LEN_W     (LEN_W)
    ) dut (
        .clk  (clk),
        .arstn(arstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mosi_q[$];
    logic [7:0] rx_q[$];
    logic [1:0] st_q[$];

    logic [7:0] tx_bytes [0:255];
    logic [7:0] miso     [0:511];

    int loads_total = 0;
    int sess_total  = 0;
    int nb_total    = 0;
    int done_total  = 0;

    bit feeding = 1'b0;
    int f_idx   = 0;
    int f_k     = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic core_load();
        loads_total++;
        n_cmp++;
        if (mosi_q.size() == 0) begin
            n_bad++;
            $display("FAIL mosi_extra: got %0h, want no byte",
                     bus.spi_byte_2_send);
        end else begin
            logic [7:0] e;
            e = mosi_q.pop_front();
            if (bus.spi_byte_2_send !== e) begin
                n_bad++;
                $display("FAIL mosi: got %0h, want %0h",
                         bus.spi_byte_2_send, e);
            end
        end
    endtask

    // SPI core model: 8 SCL periods per byte, end_trans for one period,
    // reload while enabled, otherwise release chip select.
    bit c_act   = 1'b0;
    bit c_phase = 1'b0;
    int c_cnt   = 0;
    int c_compl = 0;

    always @(negedge clk) begin
        bus.spi_new_byte = 1'b0;
        if (!arstn) begin
            c_act             = 1'b0;
            c_phase           = 1'b0;
            c_cnt             = 0;
            bus.spi_end_trans = 1'b0;
        end else if (!c_act) begin
            if (bus.spi_ena) begin
                c_act   = 1'b1;
                c_phase = 1'b0;
                c_cnt   = 0;
                c_compl = 0;
                sess_total++;
                core_load();
            end
        end else begin
            c_cnt++;
            if (!c_phase && c_cnt == 8 * P) begin
                bus.spi_byte_received = miso[c_compl];
                c_compl++;
                nb_total++;
                bus.spi_end_trans = 1'b1;
                bus.spi_new_byte  = 1'b1;
                c_phase = 1'b1;
                c_cnt   = 0;
            end else if (c_phase && c_cnt == P) begin
                bus.spi_end_trans = 1'b0;
                c_phase = 1'b0;
                c_cnt   = 0;
                if (bus.spi_ena) core_load();
                else c_act = 1'b0;
            end
        end
    end

    // tx source: offers the first f_k bytes back to back
    always @(negedge clk) begin
        if (feeding && f_idx < f_k) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = tx_bytes[f_idx];
            if (bus.tx_ready) f_idx++;
        end else begin
            bus.tx_valid = 1'b0;
        end
    end

    // Output monitor: rx bytes and command completion
    always @(negedge clk) begin
        if (arstn) begin
            if (bus.rx_valid) begin
                if (rx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_extra: got %0h, want no byte",
                             bus.rx_data);
                end else begin
                    check("rx_data", bus.rx_data, rx_q.pop_front());
                end
            end
            if (bus.done) begin
                done_total++;
                if (st_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_extra: got done, want none");
                end else begin
                    check("status", bus.status, st_q.pop_front());
                end
                check("busy_at_done", bus.busy, 0);
            end
        end
    end

    // ab: -1 none, -2 abort while waiting for the first tx byte,
    // j>=0 abort raised during byte j.
    task automatic run_cmd(input int wr, input int rd, input int k,
                           input int ab, input bit poke);
        int total, nb, st, sb, nbb, dcnt, lb, t;
        total = wr + rd;
        nb    = total;
        st    = 0;
        if (ab == -2) begin
            nb = 0;
            st = 2;
        end else begin
            if (k < wr) begin
                nb = k;
                st = 1;
            end
            if (ab >= 0 && ab + 1 <= nb && ab + 1 < total) begin
                nb = ab + 1;
                st = 2;
            end
        end
        for (int i = 0; i < nb; i++)
            mosi_q.push_back(i < wr ? tx_bytes[i] : DUMMY);
        for (int i = wr; i < nb; i++)
            rx_q.push_back(miso[i]);
        st_q.push_back(2'(st));

        lb   = loads_total;
        sb   = sess_total;
        nbb  = nb_total;
        dcnt = done_total;
        f_idx   = 0;
        f_k     = k;
        feeding = 1'b1;

        @(negedge clk);
        bus.start  = 1'b1;
        bus.wr_len = 8'(wr);
        bus.rd_len = 8'(rd);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_T1", bus.busy, 1);
        check("ena_T1", bus.spi_ena, 0);

        if (ab == -2) begin
            repeat (3) @(negedge clk);
            bus.abort = 1'b1;
        end else if (ab >= 0) begin
            t = 0;
            while (loads_total < lb + ab + 1 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            repeat (5) @(negedge clk);
            bus.abort = 1'b1;
        end

        if (poke) begin
            repeat (10) @(negedge clk);
            bus.start  = 1'b1;
            bus.wr_len = 8'd5;
            bus.rd_len = 8'd5;
            @(negedge clk);
            bus.start = 1'b0;
        end

        t = 0;
        while (done_total == dcnt && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_total == dcnt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done, want done");
        end
        bus.abort = 1'b0;
        feeding   = 1'b0;
        repeat (2) @(negedge clk);
        check("bytes", nb_total - nbb, nb);
        check("sessions", sess_total - sb, nb > 0 ? 1 : 0);
        check("mosi_left", mosi_q.size(), 0);
        check("rx_left", rx_q.size(), 0);
        check("st_left", st_q.size(), 0);
        check("busy_idle", bus.busy, 0);
    endtask

    initial begin
        int wr, rd, k, ab, nb0, lb, t, dcnt;
        bus.start             = 1'b0;
        bus.wr_len            = '0;
        bus.rd_len            = '0;
        bus.abort             = 1'b0;
        bus.tx_data           = '0;
        bus.tx_valid          = 1'b0;
        bus.spi_byte_received = '0;
        bus.spi_end_trans     = 1'b0;
        bus.spi_new_byte      = 1'b0;
        arstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_status", bus.status, 0);
        check("rst_tx_ready", bus.tx_ready, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_ena", bus.spi_ena, 0);
        check("rst_b2s", bus.spi_byte_2_send, 0);
        arstn = 1'b1;
        @(negedge clk);

        tx_bytes[0] = 8'h9F;
        miso[0] = 8'h00;
        miso[1] = 8'hEF;
        miso[2] = 8'h40;
        run_cmd(1, 2, 1, -1, 1'b0);

        tx_bytes[0] = 8'h02;
        tx_bytes[1] = 8'h00;
        tx_bytes[2] = 8'h10;
        tx_bytes[3] = 8'hAA;
        run_cmd(4, 0, 4, -1, 1'b1);

        tx_bytes[0] = 8'h5A;
        tx_bytes[1] = 8'hC3;
        tx_bytes[2] = 8'h11;
        run_cmd(3, 1, 2, -1, 1'b0);

        for (int i = 0; i < 6; i++) miso[i] = 8'(8'h30 + i);
        run_cmd(2, 4, 2, 1, 1'b0);

        run_cmd(2, 1, 0, -2, 1'b0);

        dcnt = done_total;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.wr_len = 8'd0;
        bus.rd_len = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("zero_busy", bus.busy, 0);
        repeat (4) @(negedge clk);
        check("zero_busy_late", bus.busy, 0);
        check("zero_done", done_total, dcnt);

        // Reset while the first read byte is in flight
        for (int i = 0; i < 5; i++) begin
            tx_bytes[i] = 8'($urandom);
            miso[i]     = 8'($urandom);
        end
        for (int i = 0; i < 5; i++)
            mosi_q.push_back(i < 2 ? tx_bytes[i] : DUMMY);
        lb = loads_total;
        f_idx   = 0;
        f_k     = 2;
        feeding = 1'b1;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.wr_len = 8'd2;
        bus.rd_len = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (loads_total < lb + 3 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #1 arstn = 1'b0;
        #1;
        check("mid_rst_ena", bus.spi_ena, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rx_valid", bus.rx_valid, 0);
        check("mid_rst_b2s", bus.spi_byte_2_send, 0);
        feeding = 1'b0;
        repeat (2) @(negedge clk);
        mosi_q.delete();
        rx_q.delete();
        st_q.delete();
        @(negedge clk);
        #1 arstn = 1'b1;

        tx_bytes[0] = 8'hA5;
        miso[1] = 8'h3C;
        run_cmd(1, 1, 1, -1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            wr = $urandom_range(0, 6);
            rd = $urandom_range(0, 6);
            if (wr + rd == 0) rd = 1;
            for (int i = 0; i < wr; i++) tx_bytes[i] = 8'($urandom);
            for (int i = 0; i < wr + rd; i++) miso[i] = 8'($urandom);
            k = wr;
            if (wr > 0 && $urandom_range(0, 3) == 0)
                k = $urandom_range(1, wr);
            nb0 = (k < wr) ? k : wr + rd;
            ab = -1;
            if ($urandom_range(0, 3) == 0)
                ab = $urandom_range(0, nb0 - 1);
            run_cmd(wr, rd, k, ab, n[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
